// File: rtl/des_round_controller.sv
// DES round sequencer. Holds the L/R halves, runs 16 Feistel rounds against
// an external f-function and drives the key-schedule controls for each round.
//
// Handshakes: an input block transfers on a rising edge where InValid and
// InReady are both high and Abort is low. A result transfers on a rising edge
// where OutValid and OutReady are both high and Abort is low. A producer may
// raise valid without waiting for ready and holds its data while valid is
// high. Abort overrides both transfers.
module des_round_controller (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] InBlock,
  input  logic        Decrypt,
  input  logic        Abort,
  output logic [31:0] FRight,
  input  logic [31:0] FResult,
  output logic [3:0]  RoundIdx,
  output logic        KeyLoad,
  output logic [1:0]  KeyShift,
  output logic        KeyDir,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [63:0] OutBlock,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [31:0] lReg;
  logic [31:0] rReg;
  logic [31:0] lNext;
  logic [31:0] rNext;
  logic [3:0]  roundReg;
  logic [3:0]  roundNext;
  logic        dirReg;
  logic        dirNext;

  // State register plus datapath registers; reset clears everything at once.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      lReg     <= '0;
      rReg     <= '0;
      roundReg <= '0;
      dirReg   <= 1'b0;
    end else begin
      state    <= stateNext;
      lReg     <= lNext;
      rReg     <= rNext;
      roundReg <= roundNext;
      dirReg   <= dirNext;
    end
  end

  // Next-state and datapath update: accept in IDLE, one Feistel step per
  // ROUND cycle, hold in DONE. Abort wins over every other input.
  always_comb begin
    stateNext = state;
    lNext     = lReg;
    rNext     = rReg;
    roundNext = roundReg;
    dirNext   = dirReg;
    KeyLoad   = 1'b0;
    case (state)
      IDLE: begin
        // ResetN gating keeps KeyLoad quiet while reset is held.
        if (InValid && !Abort && ResetN) begin
          lNext     = InBlock[63:32];
          rNext     = InBlock[31:0];
          roundNext = 4'd0;
          dirNext   = Decrypt;
          KeyLoad   = 1'b1;
          stateNext = ROUND;
        end
      end
      ROUND: begin
        if (Abort) begin
          roundNext = 4'd0;
          stateNext = IDLE;
        end else begin
          lNext     = rReg;
          rNext     = lReg ^ FResult;
          // 15 + 1 wraps to 0, so DONE is entered with RoundIdx = 0.
          roundNext = roundReg + 4'd1;
          if (roundReg == 4'd15) begin
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        if (Abort || OutReady) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Key rotation per round. Decrypt starts with no rotation so that the
  // right-rotating schedule yields K16 first, then walks back to K1.
  always_comb begin
    KeyShift = 2'd0;
    if (state == ROUND) begin
      case (roundReg)
        4'd0:                KeyShift = dirReg ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15:   KeyShift = 2'd1;
        default:             KeyShift = 2'd2;
      endcase
    end
  end

  // Plain register views. OutBlock swaps halves to undo the last round's swap.
  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign FRight   = rReg;
  assign OutBlock = {rReg, lReg};
  assign RoundIdx = roundReg;
  assign KeyDir   = dirReg;
  assign DbgState = state;

endmodule

// File: tb/tb_des_round_controller.sv
// Bench for des_round_controller. Provides a full DES f-function and a key
// schedule register steered by KeyLoad/KeyShift/KeyDir, plus a transaction
// model that derives every output from standard DES subkey order.
module tb_des_round_controller;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int IP_T [0:63] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int IPI_T [0:63] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [0:47] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [0:31] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [0:55] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [0:47] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int LS_T [0:15] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX_T [0:511] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // ---------------- DES helper functions ----------------
  function automatic logic [63:0] ip(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ip[63-i] = x[64-IP_T[i]];
  endfunction
  function automatic logic [63:0] ipInv(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ipInv[63-i] = x[64-IPI_T[i]];
  endfunction
  function automatic logic [55:0] pc1(input logic [63:0] k);
    for (int i = 0; i < 56; i++) pc1[55-i] = k[64-PC1_T[i]];
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    for (int i = 0; i < 48; i++) pc2[47-i] = cd[56-PC2_T[i]];
  endfunction
  function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
    logic [27:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[26:0], y[27]};
    return y;
  endfunction
  function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
    logic [27:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[27:1]};
    return y;
  endfunction
  function automatic logic [31:0] desF(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [5:0]  six;
    logic [31:0] s;
    int          v;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      six = e[47-6*j -: 6];
      v = SBOX_T[j*64 + 16*int'({six[5], six[0]}) + int'(six[4:1])];
      s[31-4*j -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) desF[31-i] = s[32-P_T[i]];
  endfunction
  // Standard subkey Kn (n = 1..16) from cumulative left shifts.
  function automatic logic [47:0] subkey(input logic [63:0] key, input int n);
    logic [55:0] cd;
    int          total;
    cd = pc1(key);
    total = 0;
    for (int i = 0; i < n; i++) total += LS_T[i];
    return pc2({rotl(cd[55:28], total), rotl(cd[27:0], total)});
  endfunction
  // {L,R} after k rounds; decrypt uses the subkeys in reverse order.
  function automatic logic [63:0] roundState(input logic [63:0] blk, input logic dir,
                                             input logic [63:0] key, input logic zf, input int k);
    logic [31:0] l, r, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < k; i++) begin
      t = zf ? 32'd0 : desF(r, subkey(key, dir ? 16 - i : i + 1));
      {l, r} = {r, l ^ t};
    end
    return {l, r};
  endfunction
  function automatic logic [63:0] finalBlock(input logic [63:0] blk, input logic dir,
                                             input logic [63:0] key, input logic zf);
    logic [63:0] lr;
    lr = roundState(blk, dir, key, zf, 16);
    return {lr[31:0], lr[63:32]};
  endfunction
  // Rotation each round must apply, straight from the DES schedule rules.
  function automatic int expShift(input int idx, input logic dir);
    if (dir && idx == 0) return 0;
    if (idx == 0 || idx == 1 || idx == 8 || idx == 15) return 1;
    return 2;
  endfunction

  // ---------------- clock / reset / DUT ----------------
  logic        Clk;
  logic        ResetN;
  logic        InValid, InReady, Decrypt, Abort, KeyLoad, KeyDir, OutValid, OutReady;
  logic [63:0] InBlock, OutBlock;
  logic [31:0] FRight, FResult;
  logic [3:0]  RoundIdx;
  logic [1:0]  KeyShift, dbgState;

  logic [63:0] curKey = '0;
  logic        zeroF = 1'b0;
  int          checkCount = 0;
  int          errCount = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  des_round_controller dut (
    .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .InBlock(InBlock), .Decrypt(Decrypt), .Abort(Abort), .FRight(FRight),
    .FResult(FResult), .RoundIdx(RoundIdx), .KeyLoad(KeyLoad), .KeyShift(KeyShift),
    .KeyDir(KeyDir), .OutValid(OutValid), .OutReady(OutReady), .OutBlock(OutBlock),
    .DbgState(dbgState)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- external key schedule and f-function ----------------
  logic [27:0] envC = '0, envD = '0, rotC, rotD;
  always @(posedge Clk) begin
    if (KeyLoad) {envC, envD} <= pc1(curKey);
    else         {envC, envD} <= {rotC, rotD};
  end
  always_comb begin
    rotC = KeyDir ? rotr(envC, int'(KeyShift)) : rotl(envC, int'(KeyShift));
    rotD = KeyDir ? rotr(envD, int'(KeyShift)) : rotl(envD, int'(KeyShift));
    FResult = zeroF ? 32'd0 : desF(FRight, pc2({rotC, rotD}));
  end

  // ---------------- transaction model and scoreboard ----------------
  // mPhase: -1 waiting for a block, 0..15 round number, 16 result held.
  int          mPhase = -1;
  logic        mDir = 1'b0;
  logic [63:0] mBlk = '0, mKey = '0;
  logic        mZf = 1'b0;
  int          acceptCount = 0;
  int          keyLoadCount = 0;
  logic [63:0] exp_q[$];

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      mPhase <= -1;
      mDir   <= 1'b0;
      exp_q.delete();
    end else if (mPhase == -1) begin
      if (InValid && !Abort) begin
        mPhase      <= 0;
        mDir        <= Decrypt;
        mBlk        <= InBlock;
        mKey        <= curKey;
        mZf         <= zeroF;
        acceptCount <= acceptCount + 1;
        exp_q.push_back(finalBlock(InBlock, Decrypt, curKey, zeroF));
      end
    end else if (Abort) begin
      mPhase <= -1;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else if (mPhase < 16) begin
      mPhase <= mPhase + 1;
    end else if (OutReady) begin
      mPhase <= -1;
    end
  end

  // Every-cycle comparison, sampled mid-cycle with inputs settled.
  always @(negedge Clk) begin
    if (ResetN) begin
      logic idle, rnd, done;
      logic [63:0] lr;
      idle = (mPhase == -1);
      rnd  = (mPhase >= 0 && mPhase < 16);
      done = (mPhase == 16);
      if (KeyLoad) keyLoadCount++;
      check("InReady", InReady, idle);
      check("OutValid", OutValid, done);
      check("KeyLoad", KeyLoad, idle && InValid && !Abort);
      check("RoundIdx", RoundIdx, rnd ? mPhase : 0);
      check("KeyShift", KeyShift, rnd ? expShift(mPhase, mDir) : 0);
      check("KeyDir", KeyDir, mDir);
      if (rnd) begin
        lr = roundState(mBlk, mDir, mKey, mZf, mPhase);
        check("FRight", FRight, lr[31:0]);
      end
      if (done) begin
        check("OutBlock", OutBlock, finalBlock(mBlk, mDir, mKey, mZf));
        if (OutReady && !Abort) begin
          if (exp_q.size() == 0) check("scoreboardEmpty", 64'd1, 64'd0);
          else check("scoreboardResult", OutBlock, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic resetChecks();
    check("rstInReady", InReady, 1);
    check("rstOutValid", OutValid, 0);
    check("rstKeyLoad", KeyLoad, 0);
    check("rstKeyShift", KeyShift, 0);
    check("rstKeyDir", KeyDir, 0);
    check("rstRoundIdx", RoundIdx, 0);
    check("rstOutBlock", OutBlock, 0);
    check("rstFRight", FRight, 0);
  endtask

  // Runs one block from IDLE. abortAt: -1 none, 0..15 abort in that round,
  // 16 abort while the result is held. lat counts edges from the accept edge
  // (counted as edge 1) to the edge after which OutValid is seen.
  task automatic runOp(input logic [63:0] blk, input logic dir, input logic [63:0] key,
                       input logic zf, input int abortAt, input int readyDelay,
                       input logic noise, output logic [63:0] res, output int lat);
    int n;
    res = '0;
    lat = -1;
    curKey = key;
    zeroF = zf;
    InBlock = blk; Decrypt = dir; InValid = 1'b1; Abort = 1'b0; OutReady = 1'b0;
    @(posedge Clk); #1;
    n = 1;
    InValid = noise; InBlock = {$urandom, $urandom}; Decrypt = 1'($urandom_range(0, 1));
    if (abortAt >= 0 && abortAt <= 15) begin
      repeat (abortAt) begin @(posedge Clk); #1; end
      Abort = 1'b1;
      @(posedge Clk); #1;
      Abort = 1'b0; InValid = 1'b0;
      check("abortToIdle", InReady, 1);
      check("abortNoOutValid", OutValid, 0);
    end else begin
      while (OutValid !== 1'b1 && n < 40) begin @(posedge Clk); #1; n++; end
      lat = n;
      res = OutBlock;
      if (abortAt == 16) begin
        Abort = 1'b1; OutReady = 1'($urandom_range(0, 1)); InValid = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0; OutReady = 1'b0; InValid = 1'b0;
        check("abortDoneToIdle", InReady, 1);
      end else begin
        repeat (readyDelay) begin
          check("heldNotReady", InReady, 0);
          @(posedge Clk); #1;
        end
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0; InValid = 1'b0;
      end
    end
    if (InReady !== 1'b1) begin
      ResetN = 1'b0; #1; ResetN = 1'b1;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    errCount++;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] res;
    int          lat;
    int          abortAt;
    ResetN = 1'b0; InValid = 1'b0; InBlock = '0; Decrypt = 1'b0; Abort = 1'b0; OutReady = 1'b0;
    #1;
    resetChecks();
    repeat (2) @(posedge Clk);
    #1;
    ResetN = 1'b1;

    // Identity f: sixteen swaps cancel, output shows the halves exchanged.
    runOp(64'h0123456789ABCDEF, 1'b0, KEY, 1'b1, -1, 2, 1'b0, res, lat);
    check("zeroF_result", res, 64'h89ABCDEF01234567);
    check("zeroF_latency", lat, 17);

    // Known-answer encrypt and decrypt, with a stalled consumer and stray InValid.
    runOp(ip(PT), 1'b0, KEY, 1'b0, -1, 5, 1'b1, res, lat);
    check("kat_encrypt", ipInv(res), CT);
    check("kat_enc_latency", lat, 17);
    runOp(ip(CT), 1'b1, KEY, 1'b0, -1, 5, 1'b1, res, lat);
    check("kat_decrypt", ipInv(res), PT);
    check("kat_dec_latency", lat, 17);

    // Abort at round 7, then Abort together with InValid in IDLE.
    runOp(ip(PT), 1'b0, KEY, 1'b0, 7, 0, 1'b1, res, lat);
    InValid = 1'b1; Abort = 1'b1; InBlock = {$urandom, $urandom};
    @(posedge Clk); #1;
    InValid = 1'b0; Abort = 1'b0;
    check("abortBlocksAccept", InReady, 1);

    // Reset pulse in round 10, then a clean full run straight after.
    curKey = KEY; zeroF = 1'b0; InBlock = ip(PT); Decrypt = 1'b0; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    check("roundBeforeReset", RoundIdx, 10);
    InValid = 1'b1;
    ResetN = 1'b0;
    #1;
    resetChecks();
    @(posedge Clk); #1;
    ResetN = 1'b1;
    runOp(ip(PT), 1'b0, KEY, 1'b0, -1, 1, 1'b0, res, lat);
    check("afterReset_result", ipInv(res), CT);
    check("afterReset_latency", lat, 17);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      abortAt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 16)) : -1;
      runOp({$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
            ($urandom_range(0, 7) == 0), abortAt, int'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)), res, lat);
      if (abortAt < 0 || abortAt == 16) check("rand_latency", lat, 17);
      repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
    end

    repeat (3) begin @(posedge Clk); #1; end
    check("keyLoadPulses", keyLoadCount, acceptCount);
    check("scoreboardDrained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
